// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sram_arb_pkg
// Brief    : Shared FSM state encoding and default widths for sram_rule_arbiter.
// Revision : 1.0
// ============================================================================
package sram_arb_pkg;

    localparam int c_NUM_REQ_DEF         = 2;
    localparam int c_SRAM_ADDR_WIDTH_DEF = 19;
    localparam int c_SRAM_DATA_WIDTH_DEF = 72;
    localparam int c_TIMEOUT_CYCLES_DEF  = 255;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_VLD = 2'd2,
        ST_DONE     = 2'd3
    } arb_state_t;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_rule_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_rule_arbiter
// Brief    : Round-robin arbiter giving NUM_REQ clients exclusive use of one
//            SRAM read/write port, one transaction at a time. Optional read
//            watchdog enabled by defining SRAM_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module sram_rule_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ         = c_NUM_REQ_DEF,
    parameter int SRAM_ADDR_WIDTH = c_SRAM_ADDR_WIDTH_DEF,
    parameter int SRAM_DATA_WIDTH = c_SRAM_DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES  = c_TIMEOUT_CYCLES_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   cl_req,
    input  logic [NUM_REQ-1:0]                   cl_wr,
    input  logic [NUM_REQ*SRAM_ADDR_WIDTH-1:0]   cl_addr,
    input  logic [NUM_REQ*SRAM_DATA_WIDTH-1:0]   cl_wdata,
    output logic [NUM_REQ-1:0]                   cl_gnt,
    output logic [NUM_REQ-1:0]                   cl_done,
    output logic [NUM_REQ-1:0]                   cl_err,
    output logic [SRAM_DATA_WIDTH-1:0]           cl_rdata,
    output logic                                 rd_0_req,
    output logic [SRAM_ADDR_WIDTH-1:0]           rd_0_addr,
    input  logic [SRAM_DATA_WIDTH-1:0]           rd_0_data,
    input  logic                                 rd_0_ack,
    input  logic                                 rd_0_vld,
    output logic                                 wr_0_req,
    output logic [SRAM_ADDR_WIDTH-1:0]           wr_0_addr,
    output logic [SRAM_DATA_WIDTH-1:0]           wr_0_data,
    input  logic                                 wr_0_ack
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("sram_rule_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t                   r_state;
    logic [c_IDX_W-1:0]           r_ptr;
    logic [c_IDX_W-1:0]           r_idx;
    logic                         r_wr;
    logic [NUM_REQ-1:0]           r_gnt;
    logic [NUM_REQ-1:0]           r_done;
    logic [SRAM_DATA_WIDTH-1:0]   r_rdata;
    logic                         r_rd_req;
    logic [SRAM_ADDR_WIDTH-1:0]   r_rd_addr;
    logic                         r_wr_req;
    logic [SRAM_ADDR_WIDTH-1:0]   r_wr_addr;
    logic [SRAM_DATA_WIDTH-1:0]   r_wr_data;

    logic                         w_any;
    logic [c_IDX_W-1:0]           w_sel;
    logic [NUM_REQ-1:0]           w_sel_oh;
    logic [c_IDX_W-1:0]           w_ptr_nxt;
    logic [SRAM_ADDR_WIDTH-1:0]   w_sel_addr;
    logic [SRAM_DATA_WIDTH-1:0]   w_sel_wdata;

    // First requester at or after ptr, wrapping; lowest offset wins.
    function automatic logic [c_IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [c_IDX_W-1:0] ptr
    );
        logic [c_IDX_W-1:0] sel;
        logic [c_IDX_W-1:0] idx;
        sel = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = c_IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                sel = idx;
            end
        end
        return sel;
    endfunction

    assign w_any       = |cl_req;
    assign w_sel       = rr_pick(cl_req, r_ptr);
    assign w_sel_oh    = NUM_REQ'(1) << w_sel;
    assign w_ptr_nxt   = (r_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
    assign w_sel_addr  = cl_addr[w_sel*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
    assign w_sel_wdata = cl_wdata[w_sel*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0]           r_tmo_cnt;
    logic [NUM_REQ-1:0]           r_err;
    logic                         w_tmo_fire;

    // Fires only when the current cycle is not already completing the read.
    assign w_tmo_fire = (r_tmo_cnt >= c_CNT_W'(TIMEOUT_CYCLES - 1)) &&
                        (((r_state == ST_ISSUE) && !r_wr && !rd_0_ack) ||
                         ((r_state == ST_WAIT_VLD) && !rd_0_vld));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_tmo_cnt <= '0;
        end else if (((r_state == ST_ISSUE) && !r_wr) || (r_state == ST_WAIT_VLD)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign cl_err = r_err;
`else
    assign cl_err = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_wr      <= 1'b0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_rd_req  <= 1'b0;
            r_rd_addr <= '0;
            r_wr_req  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
            r_err     <= '0;
`endif
        end else begin
            r_done <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
            r_err  <= '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_idx <= w_sel;
                        r_gnt <= w_sel_oh;
                        r_wr  <= cl_wr[w_sel];
                        if (cl_wr[w_sel]) begin
                            r_wr_req  <= 1'b1;
                            r_wr_addr <= w_sel_addr;
                            r_wr_data <= w_sel_wdata;
                        end else begin
                            r_rd_req  <= 1'b1;
                            r_rd_addr <= w_sel_addr;
                        end
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_wr) begin
                        if (wr_0_ack) begin
                            r_wr_req <= 1'b0;
                            r_done   <= r_gnt;
                            r_state  <= ST_DONE;
                        end
                    end else if (rd_0_ack) begin
                        r_rd_req <= 1'b0;
                        if (rd_0_vld) begin
                            r_rdata <= rd_0_data;
                            r_done  <= r_gnt;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT_VLD;
                        end
                    end
                end
                ST_WAIT_VLD: begin
                    if (rd_0_vld) begin
                        r_rdata <= rd_0_data;
                        r_done  <= r_gnt;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_gnt   <= '0;
                    r_ptr   <= w_ptr_nxt;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
`ifdef SRAM_ARB_TIMEOUT_EN
            // Abandon the stalled read and move the pointer past this client.
            if (w_tmo_fire) begin
                r_rd_req <= 1'b0;
                r_err    <= r_gnt;
                r_gnt    <= '0;
                r_ptr    <= w_ptr_nxt;
                r_state  <= ST_IDLE;
            end
`endif
        end
    end

    assign cl_gnt    = r_gnt;
    assign cl_done   = r_done;
    assign cl_rdata  = r_rdata;
    assign rd_0_req  = r_rd_req;
    assign rd_0_addr = r_rd_addr;
    assign wr_0_req  = r_wr_req;
    assign wr_0_addr = r_wr_addr;
    assign wr_0_data = r_wr_data;

endmodule : sram_rule_arbiter
`default_nettype wire

// File: tb/tb_sram_rule_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_rule_arbiter
// Brief    : Directed self-checking bench for sram_rule_arbiter.
// Revision : 1.0
// ============================================================================
module tb_sram_rule_arbiter;

    localparam int c_N  = 2;
    localparam int c_AW = 19;
    localparam int c_DW = 72;

    logic                   clk;
    logic                   reset;
    logic [c_N-1:0]         cl_req;
    logic [c_N-1:0]         cl_wr;
    logic [c_N*c_AW-1:0]    cl_addr;
    logic [c_N*c_DW-1:0]    cl_wdata;
    logic [c_N-1:0]         cl_gnt;
    logic [c_N-1:0]         cl_done;
    logic [c_N-1:0]         cl_err;
    logic [c_DW-1:0]        cl_rdata;
    logic                   rd_0_req;
    logic [c_AW-1:0]        rd_0_addr;
    logic [c_DW-1:0]        rd_0_data;
    logic                   rd_0_ack;
    logic                   rd_0_vld;
    logic                   wr_0_req;
    logic [c_AW-1:0]        wr_0_addr;
    logic [c_DW-1:0]        wr_0_data;
    logic                   wr_0_ack;

    int n_assert = 0;
    int n_fail   = 0;

    sram_rule_arbiter #(
        .NUM_REQ         (c_N),
        .SRAM_ADDR_WIDTH (c_AW),
        .SRAM_DATA_WIDTH (c_DW),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cl_req    (cl_req),
        .cl_wr     (cl_wr),
        .cl_addr   (cl_addr),
        .cl_wdata  (cl_wdata),
        .cl_gnt    (cl_gnt),
        .cl_done   (cl_done),
        .cl_err    (cl_err),
        .cl_rdata  (cl_rdata),
        .rd_0_req  (rd_0_req),
        .rd_0_addr (rd_0_addr),
        .rd_0_data (rd_0_data),
        .rd_0_ack  (rd_0_ack),
        .rd_0_vld  (rd_0_vld),
        .wr_0_req  (wr_0_req),
        .wr_0_addr (wr_0_addr),
        .wr_0_data (wr_0_data),
        .wr_0_ack  (wr_0_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [1:0] exp_done;
        logic [1:0] exp_gnt;

        reset     = 1'b0;
        cl_req    = '0;
        cl_wr     = '0;
        cl_addr   = '0;
        cl_wdata  = '0;
        rd_0_data = '0;
        rd_0_ack  = 1'b0;
        rd_0_vld  = 1'b0;
        wr_0_ack  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_gnt",     128'(cl_gnt),    128'h0);
        chk("rst_done",    128'(cl_done),   128'h0);
        chk("rst_err",     128'(cl_err),    128'h0);
        chk("rst_rdata",   128'(cl_rdata),  128'h0);
        chk("rst_rd_req",  128'(rd_0_req),  128'h0);
        chk("rst_rd_addr", 128'(rd_0_addr), 128'h0);
        chk("rst_wr_req",  128'(wr_0_req),  128'h0);
        chk("rst_wr_addr", 128'(wr_0_addr), 128'h0);
        chk("rst_wr_data", 128'(wr_0_data), 128'h0);
        reset = 1'b1;
        tick();
        chk("idle_gnt", 128'(cl_gnt), 128'h0);

        // Client 0 read, ack at +1, vld at +3
        cl_req  = 2'b01;
        cl_wr   = 2'b00;
        cl_addr = {19'h0, 19'h00010};
        tick();
        chk("rd_gnt",     128'(cl_gnt),    128'h1);
        chk("rd_req",     128'(rd_0_req),  128'h1);
        chk("rd_addr",    128'(rd_0_addr), 128'h10);
        chk("rd_no_wr",   128'(wr_0_req),  128'h0);
        cl_req   = 2'b00;
        rd_0_ack = 1'b1;
        tick();
        chk("rd_req_drop", 128'(rd_0_req), 128'h0);
        chk("rd_wait_done", 128'(cl_done), 128'h0);
        rd_0_ack = 1'b0;
        tick();
        chk("rd_wait_done2", 128'(cl_done), 128'h0);
        rd_0_vld  = 1'b1;
        rd_0_data = 72'hAB_CDEF_0123_4567_89;
        tick();
        chk("rd_done",      128'(cl_done),  128'h1);
        chk("rd_rdata",     128'(cl_rdata), 128'hAB_CDEF_0123_4567_89);
        chk("rd_done_gnt",  128'(cl_gnt),   128'h1);
        rd_0_vld  = 1'b0;
        rd_0_data = '0;
        tick();
        chk("rd_done_end",  128'(cl_done),  128'h0);
        chk("rd_gnt_clr",   128'(cl_gnt),   128'h0);
        chk("rd_rdata_hold", 128'(cl_rdata), 128'hAB_CDEF_0123_4567_89);

        // Continuous writes from both clients after reset: 3-cycle alternation
        reset = 1'b0;
        tick();
        reset    = 1'b1;
        cl_req   = 2'b11;
        cl_wr    = 2'b11;
        cl_addr  = {19'h00022, 19'h00011};
        wr_0_ack = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_gnt  = (((i - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
            exp_done = (i % 3 == 2) ? exp_gnt : 2'b00;
            if (i % 3 == 0) exp_gnt = 2'b00;
            chk("rr_done", 128'(cl_done), 128'(exp_done));
            chk("rr_gnt",  128'(cl_gnt),  128'(exp_gnt));
            chk("rr_excl", 128'(rd_0_req & wr_0_req), 128'h0);
            if (i == 11) begin
                cl_req   = 2'b00;
                wr_0_ack = 1'b0;
            end
        end

        // Client 1 write to top address, ack held off 5 cycles
        cl_req   = 2'b10;
        cl_wr    = 2'b10;
        cl_addr  = {19'h7FFFF, 19'h0};
        cl_wdata = {{72{1'b1}}, 72'h0};
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("wr_req_held", 128'(wr_0_req), 128'h1);
            chk("wr_no_done",  128'(cl_done),  128'h0);
            if (i == 1) begin
                chk("wr_gnt",  128'(cl_gnt),    128'h2);
                chk("wr_addr", 128'(wr_0_addr), 128'h7FFFF);
                chk("wr_data", 128'(wr_0_data), 128'hFF_FFFF_FFFF_FFFF_FFFF);
                cl_req = 2'b00;
            end
            if (i == 6) wr_0_ack = 1'b1;
        end
        tick();
        chk("wr_done",     128'(cl_done),  128'h2);
        chk("wr_req_drop", 128'(wr_0_req), 128'h0);
        wr_0_ack = 1'b0;
        tick();
        chk("wr_done_once", 128'(cl_done), 128'h0);
        chk("wr_gnt_clr",   128'(cl_gnt),  128'h0);

        // Same-cycle ack and vld skip WAIT_VLD; stray vld in DONE ignored
        cl_req  = 2'b01;
        cl_wr   = 2'b00;
        cl_addr = {19'h0, 19'h00123};
        tick();
        chk("fast_gnt",  128'(cl_gnt),    128'h1);
        chk("fast_addr", 128'(rd_0_addr), 128'h123);
        cl_req    = 2'b00;
        rd_0_ack  = 1'b1;
        rd_0_vld  = 1'b1;
        rd_0_data = 72'h12_3456_789A_BCDE_F011;
        tick();
        chk("fast_done",  128'(cl_done),  128'h1);
        chk("fast_rdata", 128'(cl_rdata), 128'h12_3456_789A_BCDE_F011);
        chk("fast_req",   128'(rd_0_req), 128'h0);
        rd_0_ack  = 1'b0;
        rd_0_vld  = 1'b1;
        rd_0_data = 72'h55;
        tick();
        chk("stray_vld_rdata", 128'(cl_rdata), 128'h12_3456_789A_BCDE_F011);
        chk("stray_vld_done",  128'(cl_done),  128'h0);
        rd_0_vld  = 1'b0;
        rd_0_data = '0;

        // Reset during WAIT_VLD; ptr is 1 so client 1 wins first
        cl_req  = 2'b11;
        cl_wr   = 2'b00;
        cl_addr = {19'h00200, 19'h00100};
        tick();
        chk("mrst_gnt",  128'(cl_gnt),    128'h2);
        chk("mrst_addr", 128'(rd_0_addr), 128'h200);
        rd_0_ack = 1'b1;
        tick();
        rd_0_ack = 1'b0;
        chk("mrst_wait_req", 128'(rd_0_req), 128'h0);
        reset = 1'b0;
        #1;
        chk("mrst_gnt0",   128'(cl_gnt),    128'h0);
        chk("mrst_rdata0", 128'(cl_rdata),  128'h0);
        chk("mrst_addr0",  128'(rd_0_addr), 128'h0);
        chk("mrst_done0",  128'(cl_done),   128'h0);
        tick();
        chk("mrst_done_hold", 128'(cl_done), 128'h0);
        reset = 1'b1;
        tick();
        chk("post_rst_gnt",  128'(cl_gnt),    128'h1);
        chk("post_rst_addr", 128'(rd_0_addr), 128'h100);
        chk("post_rst_done", 128'(cl_done),   128'h0);
        rd_0_ack  = 1'b1;
        rd_0_vld  = 1'b1;
        rd_0_data = 72'h0F;
        tick();
        chk("post_rst_cpl", 128'(cl_done), 128'h1);
        rd_0_ack = 1'b0;
        rd_0_vld = 1'b0;
        cl_req   = 2'b00;
        tick();

`ifdef SRAM_ARB_TIMEOUT_EN
        // Read acked, no vld: cl_err after 8 cycles, next client granted
        cl_req  = 2'b11;
        cl_wr   = 2'b00;
        cl_addr = {19'h00300, 19'h00301};
        tick();
        chk("tmo_gnt", 128'(cl_gnt), 128'h2);
        rd_0_ack = 1'b1;
        tick();
        rd_0_ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("tmo_no_err", 128'(cl_err), 128'h0);
            tick();
        end
        chk("tmo_err",     128'(cl_err),   128'h2);
        chk("tmo_no_done", 128'(cl_done),  128'h0);
        chk("tmo_gnt_clr", 128'(cl_gnt),   128'h0);
        chk("tmo_rd_req",  128'(rd_0_req), 128'h0);
        tick();
        chk("tmo_next_gnt", 128'(cl_gnt), 128'h1);
        chk("tmo_err_end",  128'(cl_err), 128'h0);
        rd_0_ack  = 1'b1;
        rd_0_vld  = 1'b1;
        rd_0_data = 72'h77;
        tick();
        chk("tmo_next_done", 128'(cl_done), 128'h1);
        rd_0_ack = 1'b0;
        rd_0_vld = 1'b0;
        cl_req   = 2'b00;
        tick();
`else
        // Without the watchdog a stalled read waits indefinitely
        cl_req  = 2'b10;
        cl_wr   = 2'b00;
        cl_addr = {19'h00300, 19'h0};
        tick();
        chk("nowd_gnt", 128'(cl_gnt), 128'h2);
        cl_req   = 2'b00;
        rd_0_ack = 1'b1;
        tick();
        rd_0_ack = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("nowd_err",  128'(cl_err),  128'h0);
        chk("nowd_gnt2", 128'(cl_gnt),  128'h2);
        chk("nowd_done", 128'(cl_done), 128'h0);
        rd_0_vld  = 1'b1;
        rd_0_data = 72'h77;
        tick();
        chk("nowd_cpl",   128'(cl_done),  128'h2);
        chk("nowd_rdata", 128'(cl_rdata), 128'h77);
        rd_0_vld = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_sram_rule_arbiter
`default_nettype wire
